// File: rtl/noc_pkg.sv
// Shared flit and channel types for the crosspoint injection path.
// Used by the injection arbiter and its round-robin sub-block.
package noc_pkg;

    localparam int PLD_W = 82;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        CH_AW = 2'd0,
        CH_W  = 2'd1,
        CH_AR = 2'd2
    } chan_e;

    typedef struct packed {
        logic              head;
        logic              tail;
        chan_e             chan;
        logic [ID_W-1:0]   tgtid;
        logic [PLD_W-1:0]  payload;
    } flit_t;

endpackage

// File: rtl/xp_inject_arbiter_rr_arb3.sv
// Three-way round-robin arbiter: first requester at or after ptr wins.
// Grant is one-hot and suppressed entirely when en is low.
module rr_arb3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    input  logic       en,
    output logic [2:0] gnt
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 3; i++) begin
            idx = 2'((int'(ptr) + i) % 3);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xp_inject_arbiter.sv
// Merges RN-side AW, W and AR requests onto one XP injection link.
// W bursts lock the link from head to tail; packets rotate round-robin.
module xp_inject_arbiter
    import noc_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             aw_valid,
    output logic             aw_ready,
    input  logic [PLD_W-1:0] aw_payload,
    input  logic [ID_W-1:0]  aw_tgtid,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic             w_head,
    input  logic             w_tail,
    input  logic [PLD_W-1:0] w_payload,
    input  logic [ID_W-1:0]  w_tgtid,
    input  logic             ar_valid,
    output logic             ar_ready,
    input  logic [PLD_W-1:0] ar_payload,
    input  logic [ID_W-1:0]  ar_tgtid,
    output logic             link_valid,
    input  logic             link_ready,
    output logic             link_head,
    output logic             link_tail,
    output logic [1:0]       link_chan,
    output logic [PLD_W-1:0] link_payload,
    output logic [ID_W-1:0]  link_tgtid,
    output logic             err_proto,
    output logic             err_burst
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {S_IDLE, S_BURST} state_e;

    state_e          state_q, state_d;
    chan_e           rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    flit_t           flit_q, flit_d;
    logic            vld_q, vld_d;
    logic            ep_q, ep_d, eb_q, eb_d;
    logic            can_load, arb_en;
    logic [2:0]      req, gnt;
    logic            aw_rdy, w_rdy, ar_rdy;

    assign can_load = !vld_q || link_ready;
    assign arb_en   = can_load && (state_q == S_IDLE);
    assign req      = {ar_valid, w_valid && w_head, aw_valid};
    assign cnt_inc  = cnt_q + 1'b1;

    rr_arb3 u_arb (
        .req (req),
        .ptr (rr_q),
        .en  (arb_en),
        .gnt (gnt)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        flit_d  = flit_q;
        vld_d   = vld_q && !link_ready;
        ep_d    = ep_q;
        eb_d    = eb_q;
        aw_rdy  = 1'b0;
        w_rdy   = 1'b0;
        ar_rdy  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // headless W is swallowed without waiting on the link
                if (w_valid && !w_head) begin
                    w_rdy = 1'b1;
                    ep_d  = 1'b1;
                end
                unique case (1'b1)
                    gnt[0]: begin
                        aw_rdy = 1'b1;
                        vld_d  = 1'b1;
                        flit_d = '{head: 1'b1, tail: 1'b1, chan: CH_AW,
                                   tgtid: aw_tgtid, payload: aw_payload};
                        rr_d   = CH_W;
                    end
                    gnt[1]: begin
                        w_rdy  = 1'b1;
                        vld_d  = 1'b1;
                        flit_d = '{head: 1'b1, tail: w_tail, chan: CH_W,
                                   tgtid: w_tgtid, payload: w_payload};
                        cnt_d  = CW'(1);
                        if (w_tail) rr_d = CH_AR;
                        else state_d = S_BURST;
                    end
                    gnt[2]: begin
                        ar_rdy = 1'b1;
                        vld_d  = 1'b1;
                        flit_d = '{head: 1'b1, tail: 1'b1, chan: CH_AR,
                                   tgtid: ar_tgtid, payload: ar_payload};
                        rr_d   = CH_AW;
                    end
                    default: ;
                endcase
            end
            S_BURST: begin
                w_rdy = can_load;
                if (w_valid && can_load) begin
                    vld_d  = 1'b1;
                    flit_d = '{head: 1'b0, tail: w_tail, chan: CH_W,
                               tgtid: w_tgtid, payload: w_payload};
                    if (w_head) ep_d = 1'b1;
                    if (w_tail) begin
                        state_d = S_IDLE;
                        rr_d    = CH_AR;
                        cnt_d   = '0;
                    end else begin
                        if (cnt_q != CW'(MAX_BURST)) cnt_d = cnt_inc;
                        if (cnt_inc >= CW'(MAX_BURST)) eb_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rr_q    <= CH_AW;
            cnt_q   <= '0;
            flit_q  <= '0;
            vld_q   <= 1'b0;
            ep_q    <= 1'b0;
            eb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            flit_q  <= flit_d;
            vld_q   <= vld_d;
            ep_q    <= ep_d;
            eb_q    <= eb_d;
        end
    end

    // readies are forced low while reset is held
    assign aw_ready     = aw_rdy && rst;
    assign w_ready      = w_rdy && rst;
    assign ar_ready     = ar_rdy && rst;
    assign link_valid   = vld_q;
    assign link_head    = flit_q.head;
    assign link_tail    = flit_q.tail;
    assign link_chan    = flit_q.chan;
    assign link_payload = flit_q.payload;
    assign link_tgtid   = flit_q.tgtid;
    assign err_proto    = ep_q;
    assign err_burst    = eb_q;

endmodule

// File: tb/tb_xp_inject_arbiter.sv
// Directed bench for xp_inject_arbiter: arbitration order, bursts,
// back-pressure, protocol errors and mid-burst reset.
module tb_xp_inject_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        aw_valid, aw_ready;
    logic [81:0] aw_payload;
    logic [1:0]  aw_tgtid;
    logic        w_valid, w_ready, w_head, w_tail;
    logic [81:0] w_payload;
    logic [1:0]  w_tgtid;
    logic        ar_valid, ar_ready;
    logic [81:0] ar_payload;
    logic [1:0]  ar_tgtid;
    logic        link_valid, link_ready, link_head, link_tail;
    logic [1:0]  link_chan;
    logic [81:0] link_payload;
    logic [1:0]  link_tgtid;
    logic        err_proto, err_burst;

    int checks = 0;
    int failures = 0;

    xp_inject_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .aw_valid     (aw_valid),
        .aw_ready     (aw_ready),
        .aw_payload   (aw_payload),
        .aw_tgtid     (aw_tgtid),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_head       (w_head),
        .w_tail       (w_tail),
        .w_payload    (w_payload),
        .w_tgtid      (w_tgtid),
        .ar_valid     (ar_valid),
        .ar_ready     (ar_ready),
        .ar_payload   (ar_payload),
        .ar_tgtid     (ar_tgtid),
        .link_valid   (link_valid),
        .link_ready   (link_ready),
        .link_head    (link_head),
        .link_tail    (link_tail),
        .link_chan    (link_chan),
        .link_payload (link_payload),
        .link_tgtid   (link_tgtid),
        .err_proto    (err_proto),
        .err_burst    (err_burst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        aw_valid = 0; aw_payload = '0; aw_tgtid = 0;
        w_valid = 0; w_head = 0; w_tail = 0; w_payload = '0; w_tgtid = 0;
        ar_valid = 0; ar_payload = '0; ar_tgtid = 0;
        link_ready = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
        #1;
    endtask

    task automatic check_rdy(input string tag, input logic [2:0] exp);
        check(tag, 128'({ar_ready, w_ready, aw_ready}), 128'(exp));
    endtask

    task automatic check_link(input string tag, input logic [1:0] ch,
                              input logic hd, input logic tl,
                              input logic [81:0] pl);
        check({tag, "_valid"}, 128'(link_valid), 128'(1'b1));
        check({tag, "_flags"}, 128'({link_chan, link_head, link_tail}),
              128'({ch, hd, tl}));
        check({tag, "_pld"}, 128'(link_payload), 128'(pl));
    endtask

    logic [1:0]  exp_ch;
    logic [81:0] exp_pl;

    initial begin
        clear_inputs();
        rst = 0;
        #2;
        check("rst_link", 128'({link_valid, link_head, link_tail, link_chan,
              link_tgtid}), 128'(0));
        check("rst_pld", 128'(link_payload), 128'(0));
        check("rst_rdy", 128'({aw_ready, w_ready, ar_ready}), 128'(0));
        check("rst_err", 128'({err_proto, err_burst}), 128'(0));
        tick();
        tick();
        rst = 1;
        #1;

        // 1: single AW
        aw_valid = 1; aw_payload = 82'h111; aw_tgtid = 2; link_ready = 1;
        #1;
        check_rdy("t1_rdy", 3'b001);
        tick();
        aw_valid = 0;
        check_link("t1_link", 2'd0, 1, 1, 82'h111);
        check("t1_tgt", 128'(link_tgtid), 128'(2));

        // 2: all three contend, round-robin from AW
        do_reset();
        aw_valid = 1; aw_payload = 82'hA0;
        w_valid = 1; w_head = 1; w_tail = 1; w_payload = 82'hB1;
        ar_valid = 1; ar_payload = 82'hC2;
        link_ready = 1;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_ch = 2'(i % 3);
            exp_pl = (exp_ch == 0) ? 82'hA0 : (exp_ch == 1) ? 82'hB1 : 82'hC2;
            check_rdy("t2_rdy", 3'b001 << exp_ch);
            tick();
            check_link("t2_link", exp_ch, 1, 1, exp_pl);
        end
        aw_valid = 0; w_valid = 0; ar_valid = 0;

        // 3: 4-flit W burst holds off AR
        do_reset();
        link_ready = 1;
        ar_valid = 1; ar_payload = 82'h3A;
        for (int i = 0; i < 4; i++) begin
            w_valid = 1; w_head = (i == 0); w_tail = (i == 3);
            w_payload = 82'h300 + 82'(i);
            #1;
            check_rdy("t3_rdy", 3'b010);
            tick();
            check_link("t3_link", 2'd1, i == 0, i == 3, 82'h300 + 82'(i));
        end
        w_valid = 0; w_head = 0; w_tail = 0;
        #1;
        check_rdy("t3_ar_rdy", 3'b100);
        tick();
        ar_valid = 0;
        check_link("t3_ar", 2'd2, 1, 1, 82'h3A);

        // 4: back-pressure holds the AR flit, then AW and AR follow
        link_ready = 0;
        aw_valid = 1; aw_payload = 82'h444;
        ar_valid = 1; ar_payload = 82'h555;
        w_valid = 1; w_head = 1; w_tail = 1; w_payload = 82'h666;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_rdy("t4_stall_rdy", 3'b000);
            check_link("t4_hold", 2'd2, 1, 1, 82'h3A);
            tick();
        end
        w_valid = 0; w_head = 0; w_tail = 0;
        link_ready = 1;
        #1;
        check_rdy("t4_rel_rdy", 3'b001);
        tick();
        aw_valid = 0;
        check_link("t4_aw", 2'd0, 1, 1, 82'h444);
        check_rdy("t4_ar_rdy", 3'b100);
        tick();
        ar_valid = 0;
        check_link("t4_ar", 2'd2, 1, 1, 82'h555);

        // 5: headless W in IDLE is dropped
        w_valid = 1; w_head = 0; w_tail = 0; w_payload = 82'h777;
        #1;
        check_rdy("t5_rdy", 3'b010);
        tick();
        w_valid = 0;
        check("t5_nolink", 128'(link_valid), 128'(0));
        check("t5_err", 128'({err_proto, err_burst}), 128'(2'b10));
        tick();
        check("t5_sticky", 128'(err_proto), 128'(1));

        // 6: runaway burst then reset mid-burst
        do_reset();
        check("t6_err_clr", 128'({err_proto, err_burst}), 128'(0));
        link_ready = 1;
        for (int i = 0; i < 17; i++) begin
            w_valid = 1; w_head = 1; w_tail = 0; w_payload = 82'h900 + 82'(i);
            #1;
            check_rdy("t6_rdy", 3'b010);
            tick();
            if (i == 14) check("t6_eb_pre", 128'(err_burst), 128'(0));
            if (i == 15) check("t6_eb", 128'(err_burst), 128'(1));
        end
        check_link("t6_last", 2'd1, 0, 0, 82'h910);
        check("t6_ep", 128'(err_proto), 128'(1));
        rst = 0;
        #1;
        check("t6_rst_link", 128'({link_valid, link_head, link_tail, link_chan,
              link_tgtid}), 128'(0));
        check("t6_rst_pld", 128'(link_payload), 128'(0));
        check("t6_rst_rdy", 128'({aw_ready, w_ready, ar_ready}), 128'(0));
        check("t6_rst_err", 128'({err_proto, err_burst}), 128'(0));
        tick();
        w_valid = 0; w_head = 0;
        rst = 1;
        aw_valid = 1; aw_payload = 82'hABC;
        #1;
        check_rdy("t6_idle_rdy", 3'b001);
        tick();
        aw_valid = 0;
        check_link("t6_idle", 2'd0, 1, 1, 82'hABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
